// File: rtl/mm_refill_ctrl_pkg.sv
// ============================================================================
// Module   : mm_refill_ctrl_pkg
// Purpose  : Shared types and constants for the I-cache refill controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mm_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_FILL   = 2'd2,
        ST_SETTLE = 2'd3
    } refill_state_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam int          CNT_REFILL_W = 20;

endpackage : mm_refill_ctrl_pkg

`default_nettype wire

// File: rtl/mm_refill_ctrl_if.sv
// ============================================================================
// Module   : mm_refill_ctrl_if
// Purpose  : Cache/memory-side signal bundle of the refill controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mm_refill_ctrl_if;
    import mm_refill_ctrl_pkg::*;

    logic [31:0]             PC;
    logic                    HitWrite;
    logic                    MM_REQ;
    logic [31:0]             MM_ADDR;
    logic                    MM_VALID;
    logic [31:0]             MM_RDATA;
    logic                    Access_MM;
    logic [31:0]             Data_MM;
    logic                    BUSY;
    logic [CNT_REFILL_W-1:0] CNT_REFILL;
    logic                    ERR_TIMEOUT;

    // master: the refill controller; slave: the cache and memory around it
    modport master (
        input  PC, HitWrite, MM_VALID, MM_RDATA,
        output MM_REQ, MM_ADDR, Access_MM, Data_MM, BUSY, CNT_REFILL, ERR_TIMEOUT
    );

    modport slave (
        output PC, HitWrite, MM_VALID, MM_RDATA,
        input  MM_REQ, MM_ADDR, Access_MM, Data_MM, BUSY, CNT_REFILL, ERR_TIMEOUT
    );

endinterface : mm_refill_ctrl_if

`default_nettype wire

// File: rtl/mm_refill_ctrl_refill_wdog.sv
// ============================================================================
// Module   : refill_wdog
// Purpose  : Saturating 8-bit wait counter flagging a stalled memory read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module refill_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic CLK,
    input  wire logic RESET,
    input  wire logic clr_i,
    input  wire logic inc_i,
    output logic      expired_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (inc_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 8'(TIMEOUT_CYCLES));

endmodule : refill_wdog

`default_nettype wire

// File: rtl/mm_refill_ctrl.sv
// ============================================================================
// Module   : mm_refill_ctrl
// Purpose  : Fetches a missing I-cache word from memory and returns it as a
//            one-cycle fill strobe. Optional macro: REFILL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mm_refill_ctrl
    import mm_refill_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic        CLK,
    input  wire logic        RESET,
    mm_refill_ctrl_if.master bus
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..255");
    end

    refill_state_e           state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic [CNT_REFILL_W-1:0] cnt_q, cnt_d;
    logic                    req_q, req_d;
    logic                    acc_q, acc_d;
    logic                    busy_q, busy_d;

`ifdef REFILL_TIMEOUT_EN
    logic w_expired;
    logic err_q, err_d;

    refill_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .CLK       (CLK),
        .RESET     (RESET),
        .clr_i     (state_q != ST_REQ),
        .inc_i     ((state_q == ST_REQ) && !bus.MM_VALID),
        .expired_o (w_expired)
    );
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef REFILL_TIMEOUT_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!bus.HitWrite) begin
                    addr_d  = {bus.PC[31:2], 2'b00};
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Returning data beats a simultaneous expiry
                if (bus.MM_VALID) begin
                    data_d  = bus.MM_RDATA;
                    state_d = ST_FILL;
                end
`ifdef REFILL_TIMEOUT_EN
                else if (w_expired) begin
                    data_d  = NOP_INSTR;
                    err_d   = 1'b1;
                    state_d = ST_FILL;
                end
`endif
            end
            ST_FILL: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_SETTLE;
            end
            // The cache's HitWrite is still stale here, so it is not looked at
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        req_d  = (state_d == ST_REQ);
        acc_d  = (state_d == ST_FILL);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
        end
    end

`ifdef REFILL_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.ERR_TIMEOUT = err_q;
`else
    assign bus.ERR_TIMEOUT = 1'b0;
`endif

    assign bus.MM_REQ     = req_q;
    assign bus.MM_ADDR    = addr_q;
    assign bus.Access_MM  = acc_q;
    assign bus.Data_MM    = data_q;
    assign bus.BUSY       = busy_q;
    assign bus.CNT_REFILL = cnt_q;

endmodule : mm_refill_ctrl

`default_nettype wire

// File: tb/tb_mm_refill_ctrl.sv
// ============================================================================
// Module   : tb_mm_refill_ctrl
// Purpose  : Randomized self-checking bench; plays cache and memory and
//            predicts every output from miss-relative cycle timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mm_refill_ctrl;

    localparam int unsigned TMO = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    // Reference state: what the outputs hold whenever the controller is idle
    int          m_cnt;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_err;

    mm_refill_ctrl_if bus ();

    mm_refill_ctrl #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input logic req, input logic acc, input logic busy,
                              input logic [31:0] addr, input logic [31:0] data,
                              input int cnt, input logic err);
        check("MM_REQ",      32'(bus.MM_REQ),      32'(req));
        check("Access_MM",   32'(bus.Access_MM),   32'(acc));
        check("BUSY",        32'(bus.BUSY),        32'(busy));
        check("MM_ADDR",     bus.MM_ADDR,          addr);
        check("Data_MM",     bus.Data_MM,          data);
        check("CNT_REFILL",  32'(bus.CNT_REFILL),  32'(cnt) & 32'hF_FFFF);
        check("ERR_TIMEOUT", 32'(bus.ERR_TIMEOUT), 32'(err));
    endtask

    task automatic check_idle();
        check_outs(1'b0, 1'b0, 1'b0, m_addr, m_data, m_cnt, m_err);
    endtask

    // One refill, entered and left at a negedge with the controller idle.
    // Cycle 0 is the miss; memory answers lat cycles after the first request
    // cycle, or never when mem_ok is 0 (timeout build only).
    task automatic run_txn(input logic [31:0] pc, input int lat, input logic [31:0] rdata,
                           input int gap, input logic mem_ok, input logic settle_hw);
        int          l;
        logic [31:0] fill;
        logic [31:0] addr;
        for (int g = 0; g < gap; g++) begin
            check_idle();
            bus.HitWrite = 1'b1;
            bus.PC       = $urandom;
            bus.MM_VALID = ($urandom_range(0, 3) == 0);
            bus.MM_RDATA = $urandom;
            @(negedge clk);
        end
        l    = mem_ok ? lat : int'(TMO);
        fill = mem_ok ? rdata : 32'h0;
        addr = {pc[31:2], 2'b00};
        check_idle();
        bus.HitWrite = 1'b0;
        bus.PC       = pc;
        bus.MM_VALID = $urandom_range(0, 1) != 0;
        bus.MM_RDATA = $urandom;
        @(negedge clk);
        for (int k = 1; k <= 3 + l; k++) begin
            check_outs(k <= 1 + l, k == 2 + l, 1'b1, addr,
                       (k >= 2 + l) ? fill : m_data,
                       (k >= 3 + l) ? m_cnt + 1 : m_cnt,
                       m_err | (!mem_ok && (k >= 2 + l)));
            bus.HitWrite = (k == 3 + l) ? settle_hw : 1'b0;
            bus.PC       = $urandom;
            if (k == 1 + l)
                bus.MM_VALID = mem_ok;
            else if (k >= 2 + l)
                bus.MM_VALID = $urandom_range(0, 1) != 0;
            else
                bus.MM_VALID = 1'b0;
            bus.MM_RDATA = (k == 1 + l) ? rdata : $urandom;
            @(negedge clk);
        end
        m_cnt  = (m_cnt + 1) & 32'hF_FFFF;
        m_addr = addr;
        m_data = fill;
        m_err  = m_err | !mem_ok;
    endtask

    task automatic reset_model();
        m_cnt  = 0;
        m_addr = 32'h0;
        m_data = 32'h0;
        m_err  = 1'b0;
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        n_vec        = 0;
        n_err        = 0;
        bus.HitWrite = 1'b0;
        bus.PC       = 32'h0000_0040;
        bus.MM_VALID = 1'b0;
        bus.MM_RDATA = 32'h0;
        reset_model();

        repeat (2) @(negedge clk);
        check_idle();
        rst_n = 1'b1;

        // Cold miss on the first clock after reset
        run_txn(32'h0000_0040, 3, 32'h2008_0005, 0, 1'b1, 1'b1);
        // Zero-latency memory with the miss still showing during SETTLE
        run_txn(32'h0000_0103, 0, 32'hDEAD_BEEF, 2, 1'b1, 1'b0);
        // Back-to-back misses
        run_txn(32'h0000_0044, 1, 32'h1111_2222, 0, 1'b1, 1'b0);
        run_txn(32'h0000_0048, 2, 32'h3333_4444, 0, 1'b1, 1'b1);

        for (int t = 0; t < 40; t++) begin
            run_txn($urandom, $urandom_range(0, TMO), $urandom, $urandom_range(0, 3),
                    1'b1, $urandom_range(0, 1) != 0);
        end

`ifdef REFILL_TIMEOUT_EN
        // Data on the expiry cycle wins, then a genuine timeout and its stickiness
        run_txn(32'h0000_0200, TMO, 32'hCAFE_F00D, 1, 1'b1, 1'b1);
        run_txn(32'h0000_0204, 0, 32'h0, 1, 1'b0, 1'b1);
        run_txn(32'h0000_0208, 1, 32'h5555_AAAA, 1, 1'b1, 1'b1);
`endif

        // Reset in REQ; stray memory data lands one cycle after release
        check_idle();
        bus.HitWrite = 1'b0;
        bus.PC       = 32'h0000_0300;
        bus.MM_VALID = 1'b0;
        @(negedge clk);
        check_outs(1'b1, 1'b0, 1'b1, 32'h0000_0300, m_data, m_cnt, m_err);
        bus.HitWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        bus.HitWrite = 1'b1;
        reset_model();
        #1;
        check_idle();
        @(negedge clk);
        check_idle();
        rst_n = 1'b1;
        @(negedge clk);
        check_idle();
        bus.MM_VALID = 1'b1;
        bus.MM_RDATA = 32'h7777_8888;
        @(negedge clk);
        check_idle();
        bus.MM_VALID = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle();
        end

        run_txn(32'h0000_0400, 2, 32'h9999_0000, 0, 1'b1, 1'b1);
        run_txn(32'h0000_0404, 0, 32'h0BAD_F00D, 1, 1'b1, 1'b1);
        check_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mm_refill_ctrl

`default_nettype wire
